ldpc_syndrome_seq: RTL
======================

LDPC_SYNDROME_SEQ -- requirements
Module: ldpc_syndrome_seq

Interface
REQ-001 SHALL have parameter MTX_W, default 8: width of one circulant shift entry.
REQ-002 SHALL have parameter C, default 8: number of check block-rows.
REQ-003 SHALL have parameter R, default 4: number of variable block-columns.
REQ-004 SHALL have parameter D, default 8: circulant size in bits.
REQ-005 SHALL have parameter COMBINE, default 1: 1 = XOR across block-columns (true syndrome); 0 = OR (legacy any-hit check).
REQ-006 SHALL define localparam WW = $clog2(C*D+1).
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 mtx  input  C*R*MTX_W  entry (i,j) at bits [(i*R+j)*MTX_W +: MTX_W]; all-ones = zero block.
REQ-010 in_valid  input  1  codeword offered.
REQ-011 in_ready  output  1  block can accept.
REQ-012 in_dec  input  R*D  codeword; block-column j at [j*D +: D].
REQ-013 early_exit  input  1  sampled at accept; stop at first failing row.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  result consumed.
REQ-016 out_pass  output  1  1 = all evaluated syndrome bits zero.
REQ-017 out_weight  output  WW  count of nonzero syndrome bits evaluated.
REQ-018 out_first_fail  output  clog2(C) (min 1)  index of first failing block-row; 0 if pass.
REQ-019 out_cfg_err  output  1  an evaluated entry was in [D, all-ones).

Function
REQ-020 SHALL implement states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-021 In IDLE, in_valid & in_ready SHALL capture in_dec and early_exit, clear accumulators, set row counter r=0, go to RUN.
REQ-022 In RUN, each cycle SHALL evaluate block-row r: for each j, rotated bit k = dec_j[(k+s) mod D], s = mtx(r,j); combine over j per COMBINE.
REQ-023 Entry all-ones SHALL contribute zero; entry s with D <= s < all-ones SHALL contribute zero and set cfg_err sticky.
REQ-024 Each RUN cycle SHALL add popcount of the D-bit row syndrome to weight; first nonzero row SHALL latch first_fail = r.
REQ-025 RUN -> DONE after row C-1, or after row r with nonzero syndrome when early_exit captured 1; otherwise r increments.
REQ-026 out_valid SHALL be 1 exactly in DONE; full run: out_valid rises C cycles after the accept edge; early exit at row r: r+1 cycles.
REQ-027 out_pass SHALL equal (weight == 0) while out_valid.
REQ-028 In DONE, outputs SHALL hold stable until out_valid & out_ready, then go IDLE next edge.
REQ-029 mtx SHALL be held stable by the source from accept until result handshake; no capture of mtx.
REQ-030 Weight SHALL not overflow: WW covers C*D.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, r=0, in_ready=1, out_valid=0, out_pass=0, out_weight=0, out_first_fail=0, out_cfg_err=0, captured dec=0.
REQ-032 Reset asserted in RUN or DONE SHALL abandon the codeword with no result emitted.

Verification (C=8, R=4, D=8, MTX_W=8)
REQ-033 in_dec=0, random valid mtx -> out_pass=1, weight=0, out_valid 8 cycles after accept.
REQ-034 all mtx=8'hFF, in_dec=32'hFFFFFFFF -> pass=1, weight=0, cfg_err=0.
REQ-035 mtx(0,0)=mtx(0,1)=0, rest FF, dec blocks0,1=8'hA5: COMBINE=1 -> pass=1; COMBINE=0 -> weight=4, first_fail=0.
REQ-036 mtx(2,0)=3, rest FF, dec block0=8'h01, early_exit=1 -> row-2 bit5 set, weight=1, first_fail=2, out_valid 3 cycles after accept.
REQ-037 mtx(1,2)=8'h0A, dec block2 nonzero -> cfg_err=1, row contributes zero; out_ready low 5 cycles -> outputs stable, in_ready=0.
REQ-038 rst_n low mid-RUN (r=4) -> out_valid=0, in_ready=1 after release; next codeword processes normally.

Source files
------------

// File: rtl/ldpc_syndrome_seq.sv
// Sequential QC-LDPC syndrome checker: one check block-row per cycle, with
// circulant shifts taken live from mtx. The result is reported with a valid/ready handshake.
module ldpc_syndrome_seq #(
    parameter int MTX_W   = 8,
    parameter int C       = 8,
    parameter int R       = 4,
    parameter int D       = 8,
    parameter int COMBINE = 1,
    localparam int WW     = $clog2(C*D+1),
    localparam int FW     = (C > 1) ? $clog2(C) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [C*R*MTX_W-1:0]   mtx,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [R*D-1:0]         in_dec,
    input  logic                   early_exit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_pass,
    output logic [WW-1:0]          out_weight,
    output logic [FW-1:0]          out_first_fail,
    output logic                   out_cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q;
    logic [R*D-1:0]  dec_q;
    logic            early_q;
    logic [FW-1:0]   row_q;
    logic [WW-1:0]   weight_q;
    logic [FW-1:0]   first_fail_q;
    logic            cfg_err_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            pass_q;

    logic [MTX_W-1:0] ent;
    logic [D-1:0]     blk;
    logic [D-1:0]     rot;
    logic [D-1:0]     syn_d;
    logic             cfg_hit_d;
    logic [WW-1:0]    weight_d;
    logic             row_fail;
    logic             last_row;

    // Syndrome of the current block-row, plus the running weight including it.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        ent       = '0;
        blk       = '0;
        rot       = '0;
        syn_d     = '0;
        cfg_hit_d = 1'b0;
        weight_d  = weight_q;
        for (int j = 0; j < R; j++) begin
            ent = mtx[(int'(row_q)*R + j)*MTX_W +: MTX_W];
            blk = dec_q[j*D +: D];
            rot = '0;
            if (ent == {MTX_W{1'b1}}) begin
                rot = '0;
            end else if (int'(ent) >= D) begin
                cfg_hit_d = 1'b1;
            end else begin
                // Doubling the block turns the modular index into a plain right shift.
                rot = D'({blk, blk} >> ent);
            end
            if (COMBINE != 0) syn_d = syn_d ^ rot;
            else              syn_d = syn_d | rot;
        end
        for (int k = 0; k < D; k++) begin
            weight_d = weight_d + WW'(syn_d[k]);
        end
    end

    assign row_fail = (syn_d != '0);
    assign last_row = (row_q == FW'(C-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dec_q        <= '0;
            early_q      <= 1'b0;
            row_q        <= '0;
            weight_q     <= '0;
            first_fail_q <= '0;
            cfg_err_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dec_q        <= in_dec;
                        early_q      <= early_exit;
                        row_q        <= '0;
                        weight_q     <= '0;
                        first_fail_q <= '0;
                        cfg_err_q    <= 1'b0;
                        pass_q       <= 1'b0;
                        in_ready_q   <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    weight_q <= weight_d;
                    if (cfg_hit_d) cfg_err_q <= 1'b1;
                    // A zero running weight means no earlier row has failed.
                    if (row_fail && weight_q == '0) first_fail_q <= row_q;
                    if (last_row || (early_q && row_fail)) begin
                        out_valid_q <= 1'b1;
                        pass_q      <= (weight_d == '0);
                        state_q     <= DONE;
                    end else begin
                        row_q <= row_q + FW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_pass       = pass_q;
    assign out_weight     = weight_q;
    assign out_first_fail = first_fail_q;
    assign out_cfg_err    = cfg_err_q;

endmodule
